// File: rtl/wb_rr_arbiter_if.sv
// Signal bundle between N Wishbone masters, the arbiter, and one Wishbone slave.
// The master modport is the arbiter's side (it masters the slave channel); slave is everything around it.
interface wb_rr_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
);
  localparam int unsigned SW = DW / 8;

  logic [NUM_MASTERS-1:0]    m_cyc;
  logic [NUM_MASTERS-1:0]    m_stb;
  logic [NUM_MASTERS-1:0]    m_we;
  logic [NUM_MASTERS*AW-1:0] m_addr;
  logic [NUM_MASTERS*DW-1:0] m_data;
  logic [NUM_MASTERS*SW-1:0] m_sel;
  logic [NUM_MASTERS-1:0]    m_stall;
  logic [NUM_MASTERS-1:0]    m_ack;
  logic [NUM_MASTERS-1:0]    m_err;
  logic [DW-1:0]             m_idata;

  logic                      s_cyc;
  logic                      s_stb;
  logic                      s_we;
  logic [AW-1:0]             s_addr;
  logic [DW-1:0]             s_data;
  logic [SW-1:0]             s_sel;
  logic                      s_stall;
  logic                      s_ack;
  logic                      s_err;
  logic [DW-1:0]             s_idata;

  modport master (
    input  m_cyc, m_stb, m_we, m_addr, m_data, m_sel,
    output m_stall, m_ack, m_err, m_idata,
    output s_cyc, s_stb, s_we, s_addr, s_data, s_sel,
    input  s_stall, s_ack, s_err, s_idata
  );

  modport slave (
    output m_cyc, m_stb, m_we, m_addr, m_data, m_sel,
    input  m_stall, m_ack, m_err, m_idata,
    input  s_cyc, s_stb, s_we, s_addr, s_data, s_sel,
    output s_stall, s_ack, s_err, s_idata
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave pipelined Wishbone arbiter, fixed or round-robin priority, bus held per cycle.
// Define WBARB_TIMEOUT_EN to add a watchdog that aborts a bus cycle stuck waiting on the slave.
module wb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS      = 4,
  parameter int unsigned AW               = 32,
  parameter int unsigned DW               = 32,
  parameter int unsigned MAX_OUTSTANDING  = 8,
  parameter bit          ROUND_ROBIN      = 1'b1,
  parameter bit          OPT_ZERO_ON_IDLE = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES   = 256
) (
  input  logic            CLK,
  input  logic            nRST,
  wb_rr_arbiter_if.master bus
);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned OW = $clog2(NUM_MASTERS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [OW-1:0]    pick_base, pick_idx, winner;
  logic             found;
  logic             owned, own_cyc, own_stb, own_we;
  logic [AW-1:0]    own_addr;
  logic [DW-1:0]    own_data;
  logic [SW-1:0]    own_sel;
  logic             full, cyc_c, stb_c, accept, resp, timeout;
  logic [NUM_MASTERS-1:0] stall_c, ack_c, err_c;

  // Priority scan starts at rr_ptr in rotating mode, at index 0 in fixed mode
  assign pick_base = ROUND_ROBIN ? rr_ptr_q : '0;

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      pick_idx = OW'((32'(pick_base) + i) % NUM_MASTERS);
      if (!found && bus.m_cyc[pick_idx]) begin
        found  = 1'b1;
        winner = pick_idx;
      end
    end
  end

  assign owned    = (state_q == OWNED);
  assign own_cyc  = bus.m_cyc[owner_q];
  assign own_stb  = bus.m_stb[owner_q];
  assign own_we   = bus.m_we[owner_q];
  assign own_addr = bus.m_addr[32'(owner_q) * AW +: AW];
  assign own_data = bus.m_data[32'(owner_q) * DW +: DW];
  assign own_sel  = bus.m_sel[32'(owner_q) * SW +: SW];

  assign full   = (count_q == CW'(MAX_OUTSTANDING));
  assign cyc_c  = owned & own_cyc & ~timeout;
  assign stb_c  = cyc_c & own_stb & ~full;
  assign accept = stb_c & ~bus.s_stall;
  // Responses count only against strobes this owner actually has in flight
  assign resp   = cyc_c & (bus.s_ack | bus.s_err) & (count_q != '0);

`ifdef WBARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] wd_q, wd_d;

  // Counts cycles spent waiting on the slave with strobes outstanding
  always_comb begin
    wd_d    = '0;
    timeout = 1'b0;
    if (owned && own_cyc && (count_q != '0) && !(bus.s_ack || bus.s_err)) begin
      if (wd_q == TW'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
      else                                 wd_d    = wd_q + TW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // Next-state and per-master handshake outputs
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    stall_c  = '1;
    ack_c    = '0;
    err_c    = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWNED;
          owner_d = winner;
          count_d = '0;
        end
      end
      OWNED: begin
        stall_c[owner_q] = bus.s_stall | full;
        ack_c[owner_q]   = resp & bus.s_ack;
        err_c[owner_q]   = (resp & bus.s_err) | timeout;
        if (!cyc_c) begin
          state_d = IDLE;
          count_d = '0;
          if (ROUND_ROBIN) rr_ptr_d = OW'((32'(owner_q) + 32'd1) % NUM_MASTERS);
        end else if (accept && !resp) begin
          count_d = count_q + CW'(1);
        end else if (resp && !accept) begin
          count_d = count_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bus.m_stall = stall_c;
  assign bus.m_ack   = ack_c;
  assign bus.m_err   = err_c;
  assign bus.m_idata = bus.s_idata;

  assign bus.s_cyc  = cyc_c;
  assign bus.s_stb  = stb_c;
  assign bus.s_we   = (OPT_ZERO_ON_IDLE && !stb_c) ? 1'b0 : own_we;
  assign bus.s_addr = (OPT_ZERO_ON_IDLE && !stb_c) ? '0   : own_addr;
  assign bus.s_data = (OPT_ZERO_ON_IDLE && !stb_c) ? '0   : own_data;
  assign bus.s_sel  = (OPT_ZERO_ON_IDLE && !stb_c) ? '0   : own_sel;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: a fixed-priority and a round-robin (zero-on-idle) instance share stimulus.
module tb_wb_rr_arbiter;
  logic         CLK, nRST;
  logic [3:0]   m_cyc, m_stb, m_we;
  logic [127:0] m_addr, m_data;
  logic [15:0]  m_sel;
  logic         s_stall, s_ack, s_err;
  logic [31:0]  s_idata;
  int           vectors, miscompares;

  wb_rr_arbiter_if #(.NUM_MASTERS(4), .AW(32), .DW(32)) bus_fx ();
  wb_rr_arbiter_if #(.NUM_MASTERS(4), .AW(32), .DW(32)) bus_rr ();

  assign bus_fx.m_cyc = m_cyc;     assign bus_rr.m_cyc = m_cyc;
  assign bus_fx.m_stb = m_stb;     assign bus_rr.m_stb = m_stb;
  assign bus_fx.m_we = m_we;       assign bus_rr.m_we = m_we;
  assign bus_fx.m_addr = m_addr;   assign bus_rr.m_addr = m_addr;
  assign bus_fx.m_data = m_data;   assign bus_rr.m_data = m_data;
  assign bus_fx.m_sel = m_sel;     assign bus_rr.m_sel = m_sel;
  assign bus_fx.s_stall = s_stall; assign bus_rr.s_stall = s_stall;
  assign bus_fx.s_ack = s_ack;     assign bus_rr.s_ack = s_ack;
  assign bus_fx.s_err = s_err;     assign bus_rr.s_err = s_err;
  assign bus_fx.s_idata = s_idata; assign bus_rr.s_idata = s_idata;

  wb_rr_arbiter #(.NUM_MASTERS(4), .AW(32), .DW(32), .MAX_OUTSTANDING(8), .ROUND_ROBIN(1'b0),
                  .OPT_ZERO_ON_IDLE(1'b0), .TIMEOUT_CYCLES(16))
    dut_fx (.CLK(CLK), .nRST(nRST), .bus(bus_fx.master));

  wb_rr_arbiter #(.NUM_MASTERS(4), .AW(32), .DW(32), .MAX_OUTSTANDING(8), .ROUND_ROBIN(1'b1),
                  .OPT_ZERO_ON_IDLE(1'b1), .TIMEOUT_CYCLES(16))
    dut_rr (.CLK(CLK), .nRST(nRST), .bus(bus_rr.master));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_data = '0; m_sel = '0;
    s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_idata = '0;
  endtask

  // Leaves the bench one step after a rising edge with reset released and both arbiters idle
  task automatic apply_reset();
    nRST = 1'b0;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    nRST = 1'b0;
    m_cyc = 4'hF;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (bus_fx.s_cyc !== 1'b0 || bus_rr.s_cyc !== 1'b0)
      begin miscompares++; $display("FAIL reset_s_cyc: got fx=%b rr=%b, expected 0", bus_fx.s_cyc, bus_rr.s_cyc); end
    vectors++;
    if (bus_fx.m_stall !== 4'hF || bus_rr.m_stall !== 4'hF)
      begin miscompares++; $display("FAIL reset_m_stall: got fx=%h rr=%h, expected f", bus_fx.m_stall, bus_rr.m_stall); end
    vectors++;
    if (bus_fx.m_ack !== 4'h0 || bus_fx.m_err !== 4'h0 || bus_fx.s_stb !== 1'b0)
      begin miscompares++; $display("FAIL reset_ack_err: got ack=%h err=%h stb=%b, expected 0", bus_fx.m_ack, bus_fx.m_err, bus_fx.s_stb); end
    @(posedge CLK); #1 nRST = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus_fx.m_stall !== 4'hF || bus_fx.s_cyc !== 1'b0)
      begin miscompares++; $display("FAIL reset_arb_latency: got stall=%h cyc=%b, expected f/0", bus_fx.m_stall, bus_fx.s_cyc); end
    @(negedge CLK);
    vectors++;
    if (bus_fx.m_stall !== 4'b1110 || bus_rr.m_stall !== 4'b1110 || bus_fx.s_cyc !== 1'b1)
      begin miscompares++; $display("FAIL reset_grant0: got fx=%h rr=%h cyc=%b, expected e/e/1", bus_fx.m_stall, bus_rr.m_stall, bus_fx.s_cyc); end
  endtask

  task automatic test_fixed();
    apply_reset();
    m_cyc = 4'b1010;
    for (int r = 0; r < 3; r++) begin
      @(negedge CLK);
      vectors++;
      if (bus_fx.m_stall !== 4'hF || bus_fx.s_cyc !== 1'b0)
        begin miscompares++; $display("FAIL fixed_idle r=%0d: got stall=%h cyc=%b, expected f/0", r, bus_fx.m_stall, bus_fx.s_cyc); end
      @(posedge CLK); #1;
      m_stb = 4'b1010;
      m_addr = {$urandom, $urandom, $urandom, $urandom};
      @(negedge CLK);
      vectors++;
      if (bus_fx.m_stall !== 4'b1101)
        begin miscompares++; $display("FAIL fixed_owner r=%0d: got stall=%h, expected d", r, bus_fx.m_stall); end
      vectors++;
      if (bus_fx.s_stb !== 1'b1 || bus_fx.s_addr !== m_addr[63:32])
        begin miscompares++; $display("FAIL fixed_stb r=%0d: got stb=%b addr=%h, expected 1/%h", r, bus_fx.s_stb, bus_fx.s_addr, m_addr[63:32]); end
      @(posedge CLK); #1;
      m_stb = '0;
      m_cyc = 4'b1000;
      @(negedge CLK);
      vectors++;
      if (bus_fx.s_cyc !== 1'b0 || bus_fx.m_stall[3] !== 1'b1)
        begin miscompares++; $display("FAIL fixed_release r=%0d: got cyc=%b stall3=%b, expected 0/1", r, bus_fx.s_cyc, bus_fx.m_stall[3]); end
      @(posedge CLK); #1;
      m_cyc = 4'b1010;
    end
  endtask

  task automatic test_rr();
    logic [1:0] exp_owner;
    apply_reset();
    m_cyc = 4'hF;
    @(posedge CLK); #1;
    for (int k = 0; k < 5; k++) begin
      exp_owner = 2'(k);
      m_stb = 4'b0001 << exp_owner;
      @(negedge CLK);
      vectors++;
      if (bus_rr.m_stall !== ~(4'b0001 << exp_owner) || bus_rr.s_stb !== 1'b1)
        begin miscompares++; $display("FAIL rr_grant k=%0d: got stall=%h stb=%b, expected %h/1", k, bus_rr.m_stall, bus_rr.s_stb, ~(4'b0001 << exp_owner)); end
      @(posedge CLK); #1;
      m_stb = '0; s_ack = 1'b1;
      @(negedge CLK);
      vectors++;
      if (bus_rr.m_ack !== (4'b0001 << exp_owner))
        begin miscompares++; $display("FAIL rr_ack k=%0d: got %h, expected %h", k, bus_rr.m_ack, 4'b0001 << exp_owner); end
      @(posedge CLK); #1;
      s_ack = 1'b0; m_cyc = 4'hF & ~(4'b0001 << exp_owner);
      @(negedge CLK);
      vectors++;
      if (bus_rr.s_cyc !== 1'b0)
        begin miscompares++; $display("FAIL rr_release k=%0d: got s_cyc=%b, expected 0", k, bus_rr.s_cyc); end
      @(posedge CLK); #1;
      m_cyc = 4'hF;
      @(negedge CLK);
      vectors++;
      if (bus_rr.s_cyc !== 1'b0 || bus_rr.m_stall !== 4'hF)
        begin miscompares++; $display("FAIL rr_turnaround k=%0d: got cyc=%b stall=%h, expected 0/f", k, bus_rr.s_cyc, bus_rr.m_stall); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_backpressure();
    int acc;
    apply_reset();
    m_cyc = 4'b0100;
    @(posedge CLK); #1;
    m_stb = 4'b0100;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (bus_fx.s_stb === 1'b1 && s_stall === 1'b0) acc++;
      vectors++;
      if (bus_fx.m_stall[2] !== (c >= 8))
        begin miscompares++; $display("FAIL bp_stall c=%0d: got %b, expected %b", c, bus_fx.m_stall[2], c >= 8); end
      @(posedge CLK); #1;
    end
    vectors++;
    if (acc != 8) begin miscompares++; $display("FAIL bp_accepted: got %0d, expected 8", acc); end
    s_ack = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus_fx.m_ack !== 4'b0100 || bus_fx.m_stall[2] !== 1'b1)
      begin miscompares++; $display("FAIL bp_ack: got ack=%h stall2=%b, expected 4/1", bus_fx.m_ack, bus_fx.m_stall[2]); end
    @(posedge CLK); #1;
    s_ack = 1'b0;
    @(negedge CLK);
    vectors++;
    if (bus_fx.s_stb !== 1'b1 || bus_fx.m_stall[2] !== 1'b0)
      begin miscompares++; $display("FAIL bp_ninth: got stb=%b stall2=%b, expected 1/0", bus_fx.s_stb, bus_fx.m_stall[2]); end
    @(posedge CLK); #1;
  endtask

  task automatic test_same_cycle();
    int acc;
    apply_reset();
    m_cyc = 4'b0001;
    @(posedge CLK); #1;
    m_stb = 4'b0001;
    repeat (3) @(posedge CLK);
    #1 s_ack = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus_fx.m_ack !== 4'b0001 || bus_fx.s_stb !== 1'b1)
      begin miscompares++; $display("FAIL same_cycle_ack: got ack=%h stb=%b, expected 1/1", bus_fx.m_ack, bus_fx.s_stb); end
    @(posedge CLK); #1;
    s_ack = 1'b0;
    acc = 0;
    repeat (7) begin
      @(negedge CLK);
      if (bus_fx.s_stb === 1'b1) acc++;
      @(posedge CLK); #1;
    end
    vectors++;
    if (acc != 5) begin miscompares++; $display("FAIL same_cycle_count: got %0d more accepts, expected 5", acc); end
    m_stb = '0;
    s_ack = 1'b1;
    repeat (6) @(posedge CLK);
    #1 s_ack = 1'b0; m_cyc = '0;
    @(negedge CLK);
    vectors++;
    if (bus_fx.s_cyc !== 1'b0) begin miscompares++; $display("FAIL drop_s_cyc: got %b, expected 0", bus_fx.s_cyc); end
    @(posedge CLK); #1;
    s_ack = 1'b1;
    @(negedge CLK);
    vectors++;
    if (bus_fx.m_ack !== 4'h0) begin miscompares++; $display("FAIL late_ack_idle: got %h, expected 0", bus_fx.m_ack); end
    @(posedge CLK); #1;
    m_cyc = 4'b0001;
    @(posedge CLK); #1;
    @(negedge CLK);
    vectors++;
    if (bus_fx.m_ack !== 4'h0 || bus_fx.s_cyc !== 1'b1)
      begin miscompares++; $display("FAIL late_ack_cleared: got ack=%h cyc=%b, expected 0/1", bus_fx.m_ack, bus_fx.s_cyc); end
    @(posedge CLK); #1;
    s_ack = 1'b0;
  endtask

`ifdef WBARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    m_cyc = 4'b0001;
    @(posedge CLK); #1;
    m_stb = 4'b0001;
    @(posedge CLK); #1;
    m_stb = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      vectors++;
      if (bus_fx.m_err !== ((k == 16) ? 4'b0001 : 4'b0000) || bus_fx.s_cyc !== (k != 16))
        begin miscompares++; $display("FAIL timeout k=%0d: got err=%h cyc=%b", k, bus_fx.m_err, bus_fx.s_cyc); end
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    vectors++;
    if (bus_fx.m_stall !== 4'hF) begin miscompares++; $display("FAIL timeout_idle: got stall=%h, expected f", bus_fx.m_stall); end
    @(posedge CLK); #1;
  endtask
`endif

  // Reference: bus ownership per master index, outstanding count as an integer
  task automatic test_random(input int n);
    bit         own [2];
    logic [1:0] owner [2];
    logic [1:0] rr [2];
    int         cnt [2];
    logic [1:0] base, idx;
    bit         found, acc, rsp;
    logic       e_cyc, e_stb, o_cyc, o_stb, o_we;
    logic [3:0] e_stall, e_ack, e_err, o_stall, o_ack, o_err;
    logic [31:0] o_addr, e_addr;
    apply_reset();
    for (int d = 0; d < 2; d++) begin own[d] = 0; owner[d] = '0; rr[d] = '0; cnt[d] = 0; end
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) m_cyc[i] = ~m_cyc[i];
      m_stb = 4'($urandom); m_we = 4'($urandom); m_sel = 16'($urandom);
      m_addr = {$urandom, $urandom, $urandom, $urandom};
      m_data = {$urandom, $urandom, $urandom, $urandom};
      s_stall = ($urandom_range(0, 3) == 0);
      s_ack = ($urandom_range(0, 1) == 0);
      s_err = ($urandom_range(0, 15) == 0);
      s_idata = $urandom;
      @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
        o_cyc = d ? bus_rr.s_cyc : bus_fx.s_cyc;     o_stb = d ? bus_rr.s_stb : bus_fx.s_stb;
        o_stall = d ? bus_rr.m_stall : bus_fx.m_stall; o_ack = d ? bus_rr.m_ack : bus_fx.m_ack;
        o_err = d ? bus_rr.m_err : bus_fx.m_err;     o_addr = d ? bus_rr.s_addr : bus_fx.s_addr;
        o_we = d ? bus_rr.s_we : bus_fx.s_we;
        e_cyc = 1'b0; e_stb = 1'b0; e_stall = 4'hF; e_ack = '0; e_err = '0;
        e_addr = m_addr[int'(owner[d]) * 32 +: 32];
        if (own[d]) begin
          e_cyc = m_cyc[owner[d]];
          e_stb = e_cyc && m_stb[owner[d]] && (cnt[d] < 8);
          e_stall[owner[d]] = s_stall || (cnt[d] == 8);
          if (e_cyc && cnt[d] > 0) begin e_ack[owner[d]] = s_ack; e_err[owner[d]] = s_err; end
        end
        vectors++;
        if ({o_cyc, o_stb, o_stall, o_ack, o_err} !== {e_cyc, e_stb, e_stall, e_ack, e_err})
          begin miscompares++; $display("FAIL rand_handshake t=%0d dut=%0d: got cyc=%b stb=%b stall=%h ack=%h err=%h, expected cyc=%b stb=%b stall=%h ack=%h err=%h",
                 t, d, o_cyc, o_stb, o_stall, o_ack, o_err, e_cyc, e_stb, e_stall, e_ack, e_err); end
        if (e_stb) begin
          vectors++;
          if (o_addr !== e_addr || o_we !== m_we[owner[d]])
            begin miscompares++; $display("FAIL rand_mux t=%0d dut=%0d: got addr=%h we=%b, expected %h/%b", t, d, o_addr, o_we, e_addr, m_we[owner[d]]); end
        end else if (d == 1) begin
          vectors++;
          if (o_addr !== 32'h0 || o_we !== 1'b0 || bus_rr.s_sel !== 4'h0)
            begin miscompares++; $display("FAIL rand_zero_idle t=%0d: got addr=%h we=%b sel=%h, expected 0", t, o_addr, o_we, bus_rr.s_sel); end
        end
        if (!own[d]) begin
          base = (d == 1) ? rr[d] : 2'd0;
          found = 0;
          for (int k = 0; k < 4; k++) begin
            idx = 2'(base + 2'(k));
            if (!found && m_cyc[idx]) begin found = 1; owner[d] = idx; end
          end
          if (found) begin own[d] = 1; cnt[d] = 0; end
        end else if (!e_cyc) begin
          own[d] = 0; cnt[d] = 0;
          if (d == 1) rr[d] = owner[d] + 2'd1;
        end else begin
          acc = e_stb && !s_stall;
          rsp = (s_ack || s_err) && (cnt[d] > 0);
          cnt[d] = cnt[d] + (acc ? 1 : 0) - (rsp ? 1 : 0);
        end
      end
      vectors++;
      if (bus_fx.m_idata !== s_idata)
        begin miscompares++; $display("FAIL rand_idata t=%0d: got %h, expected %h", t, bus_fx.m_idata, s_idata); end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    nRST = 1'b0;
    clear_inputs();
    test_reset();
    test_fixed();
    test_rr();
    test_backpressure();
    test_same_cycle();
`ifdef WBARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
